// File: rtl/bcd2bin_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
// The BIN_W legality helper is evaluated at elaboration time by bcd2bin_seq.
package bcd2bin_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StShift,
    StDone
  } state_e;

  localparam int unsigned BCD_DIGIT_W    = 4;
  localparam int unsigned BCD_MAX_DIGIT  = 9;
  localparam int unsigned BCD_ADJ_THRESH = 8;
  localparam int unsigned BCD_ADJ_SUB    = 3;

  // Smallest width that can hold 10^digits - 1.
  function automatic int unsigned min_bin_w(input int unsigned digits);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return $clog2(p);
  endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Start/done handshake bundle between a requester and the BCD-to-binary converter.
interface bcd2bin_seq_if #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned BIN_W  = 7
);

  logic                  start;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin;
  logic                  err;

  modport master (
    output start, bcd,
    input  busy, done, bin, err
  );

  modport slave (
    input  start, bcd,
    output busy, done, bin, err
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble correction for one BCD digit: subtract 3 when the digit is >= 8.
module bcd_digit_adj
  import bcd2bin_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) begin
      digit_o = digit_i - BCD_DIGIT_W'(BCD_ADJ_SUB);
    end
  end

endmodule

// File: rtl/bcd2bin_seq.sv
// Multi-cycle BCD-to-binary converter (reverse double-dabble, one bit per SHIFT cycle).
// Define BCD2BIN_CLAMP_EN to clamp illegal digits to 9 instead of aborting the conversion.
module bcd2bin_seq
  import bcd2bin_pkg::*;
#(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned BIN_W  = 7
) (
  input logic            clk,
  input logic            rst,
  bcd2bin_seq_if.slave   bus_io
);

  localparam int unsigned BcdW = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CntW = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  if (DIGITS < 1) begin : g_bad_digits
    $error("bcd2bin_seq: DIGITS must be at least 1");
  end
  if (BIN_W < min_bin_w(DIGITS)) begin : g_bad_bin_w
    $error("bcd2bin_seq: BIN_W too narrow for DIGITS");
  end

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [BcdW-1:0]   bcd_q;
  logic [BIN_W-1:0]  sr_q;
  logic              busy_q;
  logic              done_q;
  logic [BIN_W-1:0]  bin_q;
  logic              err_q;
`ifdef BCD2BIN_CLAMP_EN
  logic              err_flag_q;
  logic [BcdW-1:0]   bcd_clamped;
`endif

  logic [BcdW-1:0]   bcd_shr;
  logic [BcdW-1:0]   bcd_adj;
  logic [BIN_W-1:0]  sr_shr;
  logic              digit_bad;

  // The low BCD bit drops into the MSB of the result register each step.
  assign {bcd_shr, sr_shr} = {bcd_q, sr_q} >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (bcd_shr[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .digit_o (bcd_adj[BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    digit_bad = 1'b0;
`ifdef BCD2BIN_CLAMP_EN
    bcd_clamped = bcd_q;
`endif
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (bcd_q[BCD_DIGIT_W*d +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX_DIGIT)) begin
        digit_bad = 1'b1;
`ifdef BCD2BIN_CLAMP_EN
        bcd_clamped[BCD_DIGIT_W*d +: BCD_DIGIT_W] = BCD_DIGIT_W'(BCD_MAX_DIGIT);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bcd_q      <= '0;
      sr_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bin_q      <= '0;
      err_q      <= 1'b0;
`ifdef BCD2BIN_CLAMP_EN
      err_flag_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus_io.start) begin
            bcd_q      <= bus_io.bcd;
            sr_q       <= '0;
            busy_q     <= 1'b1;
            state_q    <= StCheck;
`ifdef BCD2BIN_CLAMP_EN
            err_flag_q <= 1'b0;
`endif
          end
        end
        StCheck: begin
          cnt_q <= '0;
          if (digit_bad) begin
`ifdef BCD2BIN_CLAMP_EN
            bcd_q      <= bcd_clamped;
            err_flag_q <= 1'b1;
            state_q    <= StShift;
`else
            done_q  <= 1'b1;
            bin_q   <= '0;
            err_q   <= 1'b1;
            state_q <= StDone;
`endif
          end else begin
            state_q <= StShift;
          end
        end
        StShift: begin
          bcd_q <= bcd_adj;
          sr_q  <= sr_shr;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(BIN_W - 1)) begin
            done_q  <= 1'b1;
            bin_q   <= sr_shr;
            state_q <= StDone;
`ifdef BCD2BIN_CLAMP_EN
            err_q   <= (bcd_adj != '0) | err_flag_q;
`else
            err_q   <= (bcd_adj != '0);
`endif
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus_io.busy = busy_q;
  assign bus_io.done = done_q;
  assign bus_io.bin  = bin_q;
  assign bus_io.err  = err_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed bench for bcd2bin_seq: 2-digit default instance plus a 3-digit/10-bit instance.
module tb_bcd2bin_seq;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bcd2bin_seq_if #(.DIGITS(2), .BIN_W(7))  bus2 ();
  bcd2bin_seq_if #(.DIGITS(3), .BIN_W(10)) bus3 ();

  bcd2bin_seq #(.DIGITS(2), .BIN_W(7)) u_dut2 (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus2)
  );

  bcd2bin_seq #(.DIGITS(3), .BIN_W(10)) u_dut3 (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus3)
  );

  // Pulse start, then wait for done; lat counts edges with the accepting edge as 1.
  task automatic run2(input logic [7:0] b, output logic [6:0] bin, output logic err,
                      output int lat, output int busy_bad);
    lat = 0; busy_bad = 0; bin = '0; err = 1'b0;
    @(negedge clk);
    bus2.bcd = b; bus2.start = 1'b1;
    @(posedge clk); #1;
    bus2.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (bus2.busy !== 1'b1) busy_bad++;
      if (bus2.done === 1'b1) begin
        lat = c; bin = bus2.bin; err = bus2.err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (bus2.busy !== 1'b0) busy_bad++;
  endtask

  task automatic run3(input logic [11:0] b, output logic [9:0] bin, output logic err,
                      output int lat);
    lat = 0; bin = '0; err = 1'b0;
    @(negedge clk);
    bus3.bcd = b; bus3.start = 1'b1;
    @(posedge clk); #1;
    bus3.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (bus3.done === 1'b1) begin
        lat = c; bin = bus3.bin; err = bus3.err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus2.start = 1'b0; bus2.bcd = '0;
    bus3.start = 1'b0; bus3.bcd = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus2.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus2.busy); end
    total++; if (bus2.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus2.done); end
    total++; if (bus2.bin !== 7'd0) begin bad++; $display("FAIL reset_bin got=%0d exp=0", bus2.bin); end
    total++; if (bus2.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus2.err); end
    total++; if (bus3.bin !== 10'd0) begin bad++; $display("FAIL reset_bin3 got=%0d exp=0", bus3.bin); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [6:0] bin; logic err; int lat, bb;
    run2(8'h21, bin, err, lat, bb);
    total++; if (lat !== 9) begin bad++; $display("FAIL basic_latency got=%0d exp=9", lat); end
    total++; if (bin !== 7'b0010101) begin bad++; $display("FAIL basic_bin got=%0d exp=21", bin); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", err); end
    total++; if (bb !== 0) begin bad++; $display("FAIL basic_busy bad_cycles=%0d exp=0", bb); end
    total++; if (bus2.bin !== 7'd21 || bus2.done !== 1'b0) begin
      bad++; $display("FAIL basic_hold bin=%0d done=%b exp bin=21 done=0", bus2.bin, bus2.done);
    end
  endtask

  task automatic test_values();
    logic [6:0] bin; logic err; int lat, bb;
    run2(8'h99, bin, err, lat, bb);
    total++; if (bin !== 7'd99 || err !== 1'b0) begin
      bad++; $display("FAIL val99 bin=%0d err=%b exp bin=99 err=0", bin, err);
    end
    run2(8'h00, bin, err, lat, bb);
    total++; if (bin !== 7'd0 || err !== 1'b0 || lat !== 9) begin
      bad++; $display("FAIL val00 bin=%0d err=%b lat=%0d exp 0/0/9", bin, err, lat);
    end
  endtask

  task automatic test_invalid();
    logic [6:0] bin; logic err; int lat, bb;
    run2(8'hA5, bin, err, lat, bb);
`ifdef BCD2BIN_CLAMP_EN
    total++; if (lat !== 9) begin bad++; $display("FAIL inv_latency got=%0d exp=9", lat); end
    total++; if (bin !== 7'd95) begin bad++; $display("FAIL inv_bin got=%0d exp=95", bin); end
`else
    total++; if (lat !== 2) begin bad++; $display("FAIL inv_latency got=%0d exp=2", lat); end
    total++; if (bin !== 7'd0) begin bad++; $display("FAIL inv_bin got=%0d exp=0", bin); end
`endif
    total++; if (err !== 1'b1) begin bad++; $display("FAIL inv_err got=%b exp=1", err); end
    total++; if (bus2.err !== 1'b1) begin bad++; $display("FAIL inv_err_hold got=%b exp=1", bus2.err); end
  endtask

  task automatic test_start_hold();
    int dones = 0, lat1 = 0, lat2 = 0;
    logic [6:0] bin1 = '0, bin2 = '0;
    @(negedge clk);
    bus2.bcd = 8'h42; bus2.start = 1'b1;
    @(posedge clk); #1;
    bus2.bcd = 8'h13;
    for (int c = 1; c <= 30; c++) begin
      if (bus2.done === 1'b1) begin
        dones++;
        if (dones == 1) begin lat1 = c; bin1 = bus2.bin; end
        if (dones == 2) begin lat2 = c; bin2 = bus2.bin; break; end
      end
      @(posedge clk); #1;
    end
    bus2.start = 1'b0;
    total++; if (lat1 !== 9 || bin1 !== 7'd42) begin
      bad++; $display("FAIL hold_first lat=%0d bin=%0d exp lat=9 bin=42", lat1, bin1);
    end
    total++; if (lat2 !== 19 || bin2 !== 7'd13) begin
      bad++; $display("FAIL hold_second lat=%0d bin=%0d exp lat=19 bin=13", lat2, bin2);
    end
    @(posedge clk); #1;
    total++; if (bus2.done !== 1'b0 || bus2.bin !== 7'd13) begin
      bad++; $display("FAIL hold_after done=%b bin=%0d exp done=0 bin=13", bus2.done, bus2.bin);
    end
  endtask

  task automatic test_rst_mid();
    logic [6:0] bin; logic err; int lat, bb;
    int dones = 0;
    @(negedge clk);
    bus2.bcd = 8'h64; bus2.start = 1'b1;
    @(posedge clk); #1;
    bus2.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (bus2.busy !== 1'b0 || bus2.done !== 1'b0 || bus2.bin !== 7'd0 ||
                 bus2.err !== 1'b0) begin
      bad++; $display("FAIL rstmid_outputs busy=%b done=%b bin=%0d err=%b exp all 0",
                      bus2.busy, bus2.done, bus2.bin, bus2.err);
    end
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (bus2.done === 1'b1) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL rstmid_nodone got=%0d exp=0", dones); end
    run2(8'h57, bin, err, lat, bb);
    total++; if (bin !== 7'd57 || err !== 1'b0 || lat !== 9) begin
      bad++; $display("FAIL rstmid_fresh bin=%0d err=%b lat=%0d exp 57/0/9", bin, err, lat);
    end
  endtask

  task automatic test_sweep();
    logic [6:0] bin; logic err; int lat, bb;
    logic [3:0] t4, u4;
    for (int t = 0; t < 10; t++) begin
      for (int u = 0; u < 10; u++) begin
        t4 = 4'(t); u4 = 4'(u);
        run2({t4, u4}, bin, err, lat, bb);
        total++;
        if (bin !== 7'(t * 10 + u) || err !== 1'b0 || lat !== 9) begin
          bad++;
          $display("FAIL sweep_%0d%0d bin=%0d err=%b lat=%0d exp %0d/0/9",
                   t, u, bin, err, lat, t * 10 + u);
        end
      end
    end
  endtask

  task automatic test_wide();
    logic [9:0] bin; logic err; int lat;
    run3(12'h999, bin, err, lat);
    total++; if (lat !== 12) begin bad++; $display("FAIL wide_latency got=%0d exp=12", lat); end
    total++; if (bin !== 10'd999 || err !== 1'b0) begin
      bad++; $display("FAIL wide_999 bin=%0d err=%b exp 999/0", bin, err);
    end
    run3(12'h100, bin, err, lat);
    total++; if (bin !== 10'd100 || err !== 1'b0) begin
      bad++; $display("FAIL wide_100 bin=%0d err=%b exp 100/0", bin, err);
    end
    run3(12'h508, bin, err, lat);
    total++; if (bin !== 10'd508 || err !== 1'b0) begin
      bad++; $display("FAIL wide_508 bin=%0d err=%b exp 508/0", bin, err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_invalid();
    test_start_hold();
    test_rst_mid();
    test_sweep();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
- Multi-cycle BCD-to-binary converter using reverse double-dabble: shift right, then subtract 3 from any BCD digit >= 8.
- Inverse of the existing binary-to-BCD path.
- Converts packed BCD digits (player entry, switch-entered bets/scores) to binary for the game-logic comparators and adders.
- Start/done handshake; one conversion in flight at a time.

Parameters:
- DIGITS, 2, number of packed BCD input digits (>= 1).
- BIN_W, 7, output binary width; must satisfy 2^BIN_W > 10^DIGITS - 1 (7 for 2 digits, 10 for 3).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request conversion; sampled only in IDLE.
- bcd  in  4*DIGITS  packed BCD, digit 0 = bcd[3:0] (units).
- busy  out  1  high from the cycle after start is accepted until done is asserted (inclusive).
- done  out  1  one-cycle pulse: result valid.
- bin  out  BIN_W  converted value; held until the next accepted start.
- err  out  1  invalid digit or residual overflow; valid with done, held with bin.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state IDLE, busy=0, done=0, bin=0, err=0, counter=0, internal shift register=0.
- Rst mid-conversion: abort; next cycle is IDLE with reset values; no done is produced.
- IDLE:
  - start=1 captures bcd into a 4*DIGITS BCD register and clears the BIN_W result shift register.
  - Go to CHECK; busy=1.
- CHECK (1 cycle):
  - Any digit > 9: go to DONE with err=1, bin=0 (no shifting).
  - Otherwise: counter=0, go to SHIFT.
- SHIFT (exactly BIN_W cycles). Each cycle:
  - Shift the concatenation {bcd_reg, bin_reg} right by 1 (bcd_reg LSB enters bin_reg MSB).
  - Then, for every digit of the shifted bcd_reg, if the digit >= 8, subtract 3 (4-bit, no borrow across digits).
  - On counter = BIN_W-1, go to DONE.
- DONE (1 cycle):
  - done=1, busy=1.
  - bin = bin_reg; err = 1 if bcd_reg residual != 0 (cannot occur with legal parameters, but checked).
  - Go to IDLE.
- Latency:
  - start sampled at edge N produces done high in the cycle after edge N+BIN_W+1, i.e. BIN_W+2 clocks after start (9 clocks at defaults).
  - Invalid-digit path: 2 clocks.
- Throughput: one conversion per BIN_W+3 cycles; start may be re-asserted in the cycle done is high, and is sampled in the following IDLE cycle.
- start while not in IDLE is ignored: no queuing, no effect on the in-flight result.
- bcd changes after the accepting edge have no effect.

Optional Feature:
- Macro: BCD2BIN_CLAMP_EN.
- Defined:
  - In CHECK, digits > 9 are replaced with 9 in bcd_reg, err=1 is latched, and SHIFT proceeds normally.
  - done arrives at normal latency; bin is the clamped value (A5 -> 95 for 2 digits).
- Undefined: abort path as described under Behaviour (err=1, bin=0, 2-clock latency).

Decomposition:
- Package bcd2bin_pkg:
  - State encoding (IDLE, CHECK, SHIFT, DONE, 2 bits).
  - Constants BCD_DIGIT_W=4, BCD_MAX_DIGIT=9, BCD_ADJ_THRESH=8, BCD_ADJ_SUB=3.
  - Function computing the minimum legal BIN_W from DIGITS, used by an elaboration-time check.
- Sub-module bcd_digit_adj: 4-bit combinational, out = (in >= 8) ? in - 3 : in.
  - Instantiated DIGITS times via generate in the SHIFT datapath.

Test Plan:
- Defaults: bcd=8'h21, pulse start -> done exactly 9 clocks after start, bin=21 (7'b0010101), err=0, busy high for cycles 1..9.
- bcd=8'h99 -> bin=99, err=0. bcd=8'h00 -> bin=0. Sweep all 100 legal inputs against a reference model.
- bcd=8'hA5, macro undefined -> done 2 clocks after start, err=1, bin=0. Macro defined -> done at 9 clocks, err=1, bin=95.
- Start at 8'h42. Hold start high and change bcd to 8'h13 while busy -> single done, bin=42. Next start accepted only after done, giving bin=13.
- Assert rst at SHIFT cycle 3 -> no done pulse, all outputs 0 next cycle. Fresh start with 8'h57 -> bin=57.
- DIGITS=3, BIN_W=10: bcd=12'h999 -> bin=999 after 12 clocks. bcd=12'h100 -> bin=100.
